alu_rr_sched: RTL and testbench



---
 rtl/alu_rr_sched.sv | 125 ++++++++++++
 tb/tb_alu_rr_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// Shares one external 8-bit ALU among N_REQ requesters; one op in flight, tagged response over valid/ready.
// Build with ALU_SCHED_FIXED_PRI_EN defined for fixed lowest-index priority instead of round-robin.
module alu_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*8-1:0] req_a,
  input  logic [N_REQ*8-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_sel,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [1:0]         alu_sel,
  input  logic [7:0]         alu_out,
  input  logic               alu_carry,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [7:0]         resp_data,
  output logic               resp_carry,
  output logic [ID_W-1:0]    resp_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic [7:0]        op_a_q, op_b_q;
  logic [1:0]        op_sel_q;
  logic [7:0]        resp_data_q;
  logic              resp_carry_q;
  logic [ID_W-1:0]   resp_id_q;
  logic              resp_valid_q;

  logic [ID_W-1:0]   search_start;
  logic [ID_W:0]     cand;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;

`ifdef ALU_SCHED_FIXED_PRI_EN
  assign search_start = '0;
`else
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
  assign search_start = rr_ptr_q;
  assign rr_ptr_d     = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  // Circular search starting at search_start, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, search_start} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Grant is combinational in IDLE; rst_n gating keeps it low while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && win_found) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRI_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            op_a_q    <= req_a[win_idx*8 +: 8];
            op_b_q    <= req_b[win_idx*8 +: 8];
            op_sel_q  <= req_sel[win_idx*2 +: 2];
            resp_id_q <= win_idx;
`ifndef ALU_SCHED_FIXED_PRI_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= alu_out;
          resp_carry_q <= alu_carry;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_carry = resp_carry_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: directed scenarios then random traffic against a transaction-level model.
module tb_alu_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        alu_carry;
  logic        resp_valid, resp_ready, resp_carry, busy;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic [8:0]  alu_res;

  alu_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_carry(resp_carry), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU stand-in.
  always_comb begin
    case (alu_sel)
      2'b00:   alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_res = {1'b0, alu_a & alu_b};
      default: alu_res = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out   = alu_res[7:0];
  assign alu_carry = alu_res[8];

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] a_v [4];
  logic [7:0] b_v [4];
  logic [1:0] sel_v [4];

  // Model: one outstanding op with its age in cycles since acceptance.
  int         rr = 0;
  bit         pend = 0;
  int         age = 0;
  int         p_id = 0;
  logic [7:0] p_a, p_b, e_data;
  logic [1:0] p_sel;
  bit         e_carry;
  int         last_acc = -1;
  logic [3:0] rdy_seen;

  int         obs_id [$];
  logic [7:0] obs_data [$];
  bit         obs_carry [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int start);
    int s;
`ifdef ALU_SCHED_FIXED_PRI_EN
    s = 0;
`else
    s = start;
`endif
    for (int k = 0; k < 4; k++)
      if (v[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic expect_result(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
    int ia, ib, s;
    ia = a; ib = b;
    case (sel)
      2'd0: begin s = ia + ib; e_data = 8'(s % 256); e_carry = (s > 255); end
      2'd1: begin s = (ia - ib + 256) % 256; e_data = 8'(s); e_carry = (ia < ib); end
      2'd2: begin e_data = a & b; e_carry = 0; end
      default: begin e_data = a | b; e_carry = 0; end
    endcase
  endtask

  // One clock cycle: drive after the rising edge, check at the falling edge, advance the model.
  task automatic cycle(input logic [3:0] v, input logic rdy);
    int w;
    req_valid  = v;
    resp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8]   = a_v[i];
      req_b[8*i +: 8]   = b_v[i];
      req_sel[2*i +: 2] = sel_v[i];
    end
    @(negedge clk);
    rdy_seen = req_ready;
    w = pick(v, rr);
    last_acc = -1;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_resp_data", resp_data, 0);
    end else if (!pend) begin
      chk("idle_req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 0);
      chk("idle_busy", busy, 0);
      chk("idle_resp_valid", resp_valid, 0);
    end else begin
      chk("busy_req_ready", req_ready, 0);
      chk("busy_busy", busy, 1);
      chk("busy_alu_opnds", {alu_sel, alu_a, alu_b}, {p_sel, p_a, p_b});
      chk("busy_resp_valid", resp_valid, (age >= 2));
      if (age >= 2) chk("resp_payload", {resp_id, resp_carry, resp_data}, {2'(p_id), e_carry, e_data});
    end
    if (resp_valid === 1'b1 && rdy) begin
      obs_id.push_back(int'(resp_id));
      obs_data.push_back(resp_data);
      obs_carry.push_back(resp_carry);
    end
    if (!rst_n) begin
      pend = 0; rr = 0;
    end else if (!pend) begin
      if (w >= 0) begin
        pend = 1; age = 1; p_id = w; last_acc = w;
        p_a = a_v[w]; p_b = b_v[w]; p_sel = sel_v[w];
        expect_result(p_a, p_b, p_sel);
        rr = (w + 1) % 4;
      end
    end else if (age == 1) begin
      age = 2;
    end else if (rdy) begin
      pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_last(input string tag, input int n_before, input int id,
                            input logic [7:0] data, input bit carry);
    chk({tag, "_count"}, obs_data.size(), n_before + 1);
    if (obs_data.size() > 0)
      chk(tag, {8'(obs_id[$]), 7'd0, obs_carry[$], obs_data[$]}, {8'(id), 7'd0, carry, data});
  endtask

  initial begin : main
    logic [3:0] cur_v;
    int n0;
    int exp_ids [5];
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_sel = '0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'(8'h11 * (i + 1)); b_v[i] = 8'(i); sel_v[i] = 2'(i);
    end
    @(posedge clk); #1;

    // T1: reset held with every requester asking.
    cycle(4'hF, 1'b1);
    cycle(4'hF, 1'b1);
    rst_n = 1'b1;
    cycle(4'h0, 1'b1);

    // T4: fairness with all requesters held valid.
    n0 = obs_id.size();
    for (int c = 0; c < 15; c++) cycle(4'hF, 1'b1);
`ifdef ALU_SCHED_FIXED_PRI_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    chk("t4_count", obs_id.size() - n0, 5);
    for (int k = 0; k < 5; k++)
      if (n0 + k < obs_id.size()) chk("t4_grant_order", obs_id[n0 + k], exp_ids[k]);

    // T2: add with carry out.
    a_v[0] = 8'hF0; b_v[0] = 8'h20; sel_v[0] = 2'b00;
    n0 = obs_data.size();
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check_last("t2_add", n0, 0, 8'h10, 1'b1);

    // T3: subtract with and without borrow.
    a_v[2] = 8'h05; b_v[2] = 8'h07; sel_v[2] = 2'b01;
    n0 = obs_data.size();
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check_last("t3_sub_borrow", n0, 2, 8'hFE, 1'b1);
    a_v[2] = 8'h07; b_v[2] = 8'h05;
    n0 = obs_data.size();
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check_last("t3_sub", n0, 2, 8'h02, 1'b0);

    // T5: response backpressure while requester 1 waits.
    a_v[1] = 8'h3C; b_v[1] = 8'hC3; sel_v[1] = 2'b11;
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    cycle(4'b0010, 1'b1);
    chk("t5_accept_after_ready", rdy_seen, 4'b0010);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // T6: reset while executing drops the op and rewinds the pointer.
    cycle(4'b0100, 1'b1);
    rst_n = 1'b0;
    cycle(4'b0100, 1'b1);
    cycle(4'b1010, 1'b1);
    rst_n = 1'b1;
    cycle(4'b1010, 1'b1);
    chk("t6_first_grant", rdy_seen, 4'b0010);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Random traffic; operands held stable while a request waits.
    cur_v = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_v[i] && last_acc != i) begin
          if ($urandom_range(7) == 0) cur_v[i] = 1'b0;
        end else begin
          cur_v[i] = 1'($urandom_range(1));
          a_v[i]   = 8'($urandom);
          b_v[i]   = 8'($urandom);
          sel_v[i] = 2'($urandom_range(3));
        end
      end
      cycle(cur_v, $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
